// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter / controller.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   localparam int unsigned NREQ_DEF  = 4;
   localparam int unsigned DEPTH_DEF = 8;
   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned BURST_DEF = 4;

endpackage

// File: rtl/fifo_arb_ctrl_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NREQ = NREQ_DEF,
   localparam int unsigned PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] pick_o,
   output logic            valid_o
);

   logic [PW-1:0] idx;

   always_comb begin
      pick_o  = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr_i) + k) % NREQ);
         if (!valid_o && req_i[idx]) begin
            pick_o[idx] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Burst-limited round-robin write arbiter that drives FIFO write/read strobes
// and tracks occupancy itself, so full/empty never depend on FIFO status lag.
module fifo_arb_ctrl
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NREQ  = NREQ_DEF,
   parameter  int unsigned DEPTH = DEPTH_DEF,
   parameter  int unsigned DW    = DW_DEF,
   parameter  int unsigned BURST = BURST_DEF,
   localparam int unsigned PW    = $clog2(NREQ),
   localparam int unsigned LW    = $clog2(DEPTH + 1),
   localparam int unsigned BW    = $clog2(BURST + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    ack,
   output logic [NREQ-1:0]    gnt,
   input  logic               rd_req,
   output logic               rd_ack,
   output logic               w_fifo,
   output logic               r_fifo,
   output logic [DW-1:0]      data_in,
   output logic [LW-1:0]      level
);

   arb_state_e      state_q, state_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [LW-1:0]   level_q, level_d;
   logic            toggle_q, toggle_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            w_q, w_d;
   logic            r_q, r_d;
   logic [DW-1:0]   data_q, data_d;

   logic [NREQ-1:0] pick;
   logic            pick_vld;
   logic [PW-1:0]   pick_idx;
   logic            own_req;
   logic            w_elig, r_elig;
   logic            do_w, do_r;

   rr_pick #(
      .NREQ(NREQ)
   ) u_rr_pick (
      .req_i  (req),
      .ptr_i  (rr_ptr_q),
      .pick_o (pick),
      .valid_o(pick_vld)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      burst_d  = burst_q;
      level_d  = level_q;
      toggle_d = toggle_q;
      ack_d    = '0;
      w_d      = 1'b0;
      r_d      = 1'b0;
      data_d   = data_q;
      pick_idx = '0;

      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = PW'(i);
      end

      own_req = req[owner_q];
      w_elig  = (state_q == OWN) && own_req && (burst_q < BW'(BURST)) && (level_q < LW'(DEPTH));
      r_elig  = rd_req && (level_q != '0);

      // toggle_q == 0 means the write side wins the next contested cycle
      do_w = w_elig && (!r_elig || !toggle_q);
      do_r = r_elig && !do_w;
      if (w_elig && r_elig) toggle_d = ~toggle_q;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = OWN;
               owner_d = pick_idx;
               burst_d = '0;
            end
         end
         OWN: begin
            if (!own_req || (burst_q == BW'(BURST))) begin
               state_d  = IDLE;
               rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_w) begin
         w_d            = 1'b1;
         data_d         = req_data[owner_q*DW +: DW];
         ack_d[owner_q] = 1'b1;
         level_d        = level_q + 1'b1;
         burst_d        = burst_q + 1'b1;
      end
      if (do_r) begin
         r_d     = 1'b1;
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
         level_q  <= '0;
         toggle_q <= 1'b0;
         ack_q    <= '0;
         w_q      <= 1'b0;
         r_q      <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         burst_q  <= burst_d;
         level_q  <= level_d;
         toggle_q <= toggle_d;
         ack_q    <= ack_d;
         w_q      <= w_d;
         r_q      <= r_d;
         data_q   <= data_d;
      end
   end

   assign gnt     = (state_q == OWN) ? (NREQ'(1) << owner_q) : '0;
   assign ack     = ack_q;
   assign rd_ack  = r_q;
   assign w_fifo  = w_q;
   assign r_fifo  = r_q;
   assign data_in = data_q;
   assign level   = level_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed bench for fifo_arb_ctrl: BURST=4 instance for the main scenarios,
// BURST=1 instance for round-robin ordering; write data checked via scoreboards.
module tb_fifo_arb_ctrl;

   localparam int NREQ  = 4;
   localparam int DEPTH = 8;
   localparam int DW    = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req, ack, gnt;
   logic [NREQ*DW-1:0] req_data;
   logic               rd_req, rd_ack, w_fifo, r_fifo;
   logic [DW-1:0]      data_in;
   logic [3:0]         level;

   logic [NREQ-1:0]    reqb, ackb, gntb;
   logic [NREQ*DW-1:0] req_datab;
   logic               rd_ackb, w_fifob, r_fifob;
   logic [DW-1:0]      data_inb;
   logic [3:0]         levelb;

   fifo_arb_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW), .BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack), .gnt(gnt),
      .rd_req(rd_req), .rd_ack(rd_ack), .w_fifo(w_fifo), .r_fifo(r_fifo),
      .data_in(data_in), .level(level)
   );

   fifo_arb_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW), .BURST(1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .req(reqb), .req_data(req_datab), .ack(ackb), .gnt(gntb),
      .rd_req(1'b0), .rd_ack(rd_ackb), .w_fifo(w_fifob), .r_fifo(r_fifob),
      .data_in(data_inb), .level(levelb)
   );

   int checks = 0;
   int errors = 0;
   int rem [NREQ];
   int cnt [NREQ];
   int remb [NREQ];
   int cntb [NREQ];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] expb_q [$];
   int gnt_log [$];
   logic [NREQ-1:0] gntb_prev = '0;
   int wcnt_b = 0;
   int exp_order [5] = '{0, 1, 2, 3, 0};

   function automatic logic [DW-1:0] gen(input int i, input int n);
      return DW'((n + 1) * 17 + i * 64);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req[i]                 = rem[i] > 0;
         req_data[i*DW +: DW]   = gen(i, cnt[i]);
         reqb[i]                = remb[i] > 0;
         req_datab[i*DW +: DW]  = gen(i, cntb[i]);
      end
   endtask

   task automatic tick();
      int idx;
      @(posedge clk);
      #1;
      chk("a_excl", 32'(w_fifo & r_fifo), 0);
      chk("a_ack", 32'(ack), 32'(w_fifo ? gnt : '0));
      chk("a_rdack", 32'(rd_ack), 32'(r_fifo));
      chk("a_lvl_max", 32'(level <= DEPTH), 1);
      if (w_fifo) begin
         chk("a_wr_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) chk("a_wdata", 32'(data_in), 32'(exp_q.pop_front()));
      end
      chk("b_ack", 32'(ackb), 32'(w_fifob ? gntb : '0));
      chk("b_rd", 32'(r_fifob | rd_ackb), 0);
      if (w_fifob) begin
         wcnt_b++;
         chk("b_wr_pending", 32'(expb_q.size() != 0), 1);
         if (expb_q.size() != 0) chk("b_wdata", 32'(data_inb), 32'(expb_q.pop_front()));
      end
      if (gntb != '0 && gntb_prev == '0) begin
         idx = -1;
         for (int i = 0; i < NREQ; i++) if (gntb[i]) idx = i;
         gnt_log.push_back(idx);
      end
      gntb_prev = gntb;
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i]) begin
            cnt[i]++;
            if (rem[i] > 0) rem[i]--;
         end
         if (ackb[i]) begin
            cntb[i]++;
            if (remb[i] > 0) remb[i]--;
         end
      end
      drive();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 0; cnt[i] = 0; remb[i] = 0; cntb[i] = 0;
      end
      rd_req = 1'b0;
      drive();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_wr", 32'(w_fifo | r_fifo | rd_ack), 0);
      chk("rst_data", 32'(data_in), 0);
      rst_n = 1'b1;

      // round robin, BURST=1, all four requesters steady
      for (int i = 0; i < NREQ; i++) remb[i] = 2;
      expb_q.push_back(gen(0, 0));
      expb_q.push_back(gen(1, 0));
      expb_q.push_back(gen(2, 0));
      expb_q.push_back(gen(3, 0));
      expb_q.push_back(gen(0, 1));
      drive();
      for (int c = 0; c < 40 && wcnt_b < 5; c++) tick();
      chk("b_writes", wcnt_b, 5);
      for (int i = 0; i < NREQ; i++) remb[i] = 0;
      drive();
      repeat (2) tick();
      chk("b_grants", gnt_log.size(), 5);
      for (int k = 0; k < gnt_log.size() && k < 5; k++) chk("b_order", gnt_log[k], exp_order[k]);
      chk("b_sb_empty", expb_q.size(), 0);
      chk("b_level", 32'(levelb), 5);
      chk("a_idle_level", 32'(level), 0);

      // single requester, five items, BURST=4
      rem[0] = 5;
      for (int n = 0; n < 5; n++) exp_q.push_back(gen(0, n));
      drive();
      tick(); chk("t1_gnt", 32'(gnt), 1); chk("t1_noack", 32'(ack), 0);
      tick(); chk("t1_ack", 32'(ack), 1); chk("t1_lvl1", 32'(level), 1);
      repeat (3) tick();
      chk("t1_lvl4", 32'(level), 4);
      tick(); chk("t1_gnt_drop", 32'(gnt), 0); chk("t1_no_wr", 32'(w_fifo), 0);
      tick(); chk("t1_regrant", 32'(gnt), 1);
      tick(); chk("t1_ack5", 32'(ack), 1); chk("t1_lvl5", 32'(level), 5);
      tick(); chk("t1_release", 32'(gnt), 0);
      chk("t1_sb_empty", exp_q.size(), 0);

      // fill to DEPTH, stall, one read then one write
      rem[0] = 4;
      for (int n = 5; n < 9; n++) exp_q.push_back(gen(0, n));
      drive();
      tick(); chk("t2_gnt", 32'(gnt), 1);
      repeat (3) tick();
      chk("t2_full", 32'(level), 8);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t2_stall_gnt", 32'(gnt), 1);
         chk("t2_stall_ack", 32'(ack), 0);
         chk("t2_stall_lvl", 32'(level), 8);
      end
      rd_req = 1'b1;
      tick(); chk("t2_rd", 32'(r_fifo), 1); chk("t2_rd_nowr", 32'(w_fifo), 0); chk("t2_lvl7", 32'(level), 7);
      rd_req = 1'b0;
      tick(); chk("t2_wr", 32'(w_fifo), 1); chk("t2_wr_ack", 32'(ack), 1); chk("t2_lvl8", 32'(level), 8);
      tick(); chk("t2_release", 32'(gnt), 0);
      chk("t2_sb_empty", exp_q.size(), 0);

      // drain to 4
      rd_req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("drain_rd", 32'(r_fifo), 1);
      end
      rd_req = 1'b0;
      chk("drain_lvl", 32'(level), 4);

      // writer and reader contend: alternate W,R starting with W
      rem[0] = 3;
      for (int n = 9; n < 12; n++) exp_q.push_back(gen(0, n));
      drive();
      tick(); chk("t3_gnt", 32'(gnt), 1);
      rd_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t3_w", 32'(w_fifo), 32'((k % 2) == 0));
         chk("t3_r", 32'(r_fifo), 32'((k % 2) == 1));
         chk("t3_lvl", 32'(level), ((k % 2) == 0) ? 5 : 4);
      end
      rd_req = 1'b0;
      tick();
      chk("t3_quiet", 32'(w_fifo | r_fifo), 0);
      chk("t3_idle", 32'(gnt), 0);
      chk("t3_sb_empty", exp_q.size(), 0);

      // reads down to empty, then no underflow
      rd_req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t4_rd", 32'(r_fifo), 1);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("t4_no_rfifo", 32'(r_fifo), 0);
         chk("t4_no_rdack", 32'(rd_ack), 0);
         chk("t4_lvl0", 32'(level), 0);
      end
      rd_req = 1'b0;

      // asynchronous reset mid-burst at level 3
      rem[2] = 5;
      for (int n = 0; n < 3; n++) exp_q.push_back(gen(2, n));
      drive();
      tick(); chk("t5_gnt2", 32'(gnt), 4);
      repeat (3) tick();
      chk("t5_lvl3", 32'(level), 3);
      chk("t5_ack2", 32'(ack), 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'(gnt), 0);
      chk("t5_rst_ack", 32'(ack), 0);
      chk("t5_rst_strobe", 32'(w_fifo | r_fifo | rd_ack), 0);
      chk("t5_rst_data", 32'(data_in), 0);
      chk("t5_rst_lvl", 32'(level), 0);
      chk("t5_rst_lvlb", 32'(levelb), 0);
      rem[2] = 0;
      rem[1] = 1;
      rem[3] = 1;
      exp_q.push_back(gen(1, cnt[1]));
      exp_q.push_back(gen(3, cnt[3]));
      drive();
      @(posedge clk);
      #1;
      chk("t5_hold_gnt", 32'(gnt), 0);
      rst_n = 1'b1;
      tick(); chk("t5_first_gnt", 32'(gnt), 2); chk("t5_no_stale", 32'(w_fifo), 0);
      tick(); chk("t5_ack1", 32'(ack), 2); chk("t5_lvl1", 32'(level), 1);
      tick(); chk("t5_idle", 32'(gnt), 0);
      tick(); chk("t5_gnt3", 32'(gnt), 8);
      tick(); chk("t5_ack3", 32'(ack), 8); chk("t5_lvl2", 32'(level), 2);
      tick(); chk("t5_end", 32'(gnt), 0);
      chk("t5_sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DEPTH, default 8, FIFO capacity in entries.
REQ-003 Parameter DW, default 8, data width.
REQ-004 Parameter BURST, default 4, maximum writes per grant (1..DEPTH).
REQ-005 clk  in  1  single clock; all state changes on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NREQ  per-requester write request, held high while data pending.
REQ-008 req_data  in  NREQ*DW  per-requester write data; slice i valid while req[i] is high.
REQ-009 ack  out  NREQ  one-hot pulse; slice i's data was taken this edge.
REQ-010 gnt  out  NREQ  one-hot current owner; all zero when idle.
REQ-011 rd_req  in  1  consumer read request.
REQ-012 rd_ack  out  1  pulse; a read strobe was issued this edge.
REQ-013 w_fifo, r_fifo  out  1 each  registered FIFO write/read strobes.
REQ-014 data_in  out  DW  registered FIFO write data.
REQ-015 level  out  $clog2(DEPTH+1)  controller-tracked FIFO occupancy.

Function
REQ-016 The FSM SHALL have states IDLE and OWN; gnt SHALL be all zero in IDLE and one-hot in OWN.
REQ-017 From IDLE with any req bit set, the block SHALL select the first set bit at or after rr_ptr (wrapping modulo NREQ), enter OWN and clear burst count.
REQ-018 In OWN, the block SHALL return to IDLE when the owner's req is low or the burst count reaches BURST, and SHALL advance rr_ptr to owner+1 mod NREQ on exit.
REQ-019 Full and empty decisions SHALL use level only, never FIFO status outputs, so the one-cycle strobe latency causes no overflow or underflow.
REQ-020 A write is eligible when in OWN, owner req is high and level<DEPTH; a read is eligible when rd_req is high and level>0.
REQ-021 At most one of w_fifo/r_fifo SHALL be asserted in any cycle.
REQ-022 If both are eligible, the block SHALL alternate using a toggle bit, write first after reset; the toggle SHALL flip only when both were eligible.
REQ-023 An issued write SHALL register w_fifo=1 and data_in=owner data, pulse ack[owner], increment level and burst count, all at the same edge.
REQ-024 An issued read SHALL register r_fifo=1, pulse rd_ack and decrement level at the same edge.
REQ-025 Latency: req high in IDLE -> gnt next edge -> first w_fifo/ack the edge after -> FIFO stores one edge later.
REQ-026 When level==DEPTH, the owner SHALL keep gnt with no ack; the stall SHALL NOT consume burst count.
REQ-027 A req dropping mid-burst SHALL end ownership with no write for that cycle.
REQ-028 level SHALL never exceed DEPTH nor go below 0; ack, rd_ack and strobes SHALL be single-cycle pulses.

Reset
REQ-029 When rst_n is low, the block SHALL immediately set: FSM IDLE, gnt=0, ack=0, rd_ack=0, w_fifo=0, r_fifo=0, data_in=0, level=0, rr_ptr=0, toggle=write-first, burst count=0.
REQ-030 Reset mid-burst SHALL drop ownership with no pending strobe after deassertion; the FIFO SHALL be reset on the same rst_n.

Structure
REQ-031 A shared package fifo_arb_pkg SHALL hold the FSM state enum and default NREQ/DEPTH/DW/BURST constants.
REQ-032 Round-robin selection SHALL be one sub-module rr_pick: inputs req and rr_ptr, outputs one-hot pick and valid.

Verification
REQ-033 Single requester req[0]=1 with data 0x11,0x22,0x33,0x44,0x55, BURST=4 -> four acks, gnt drops one cycle, regrant, fifth write; level=5.
REQ-034 All four requesters steady, BURST=1 -> gnt order 0,1,2,3,0 with one write each.
REQ-035 Fill to DEPTH=8 with rd_req=0 -> level=8, gnt held, no ack for 3 cycles; rd_req pulse -> one read, then one write.
REQ-036 Writer plus rd_req both continuous from level=4 -> strobes alternate W,R,W,R, never both; level stays 4/5.
REQ-037 rd_req with level=0 -> no r_fifo, no rd_ack.
REQ-038 rst_n low mid-burst at level=3 -> all outputs zero asynchronously; after release, first grant goes to lowest set req from index 0.
